// File: rtl/nn_param_loader.sv
// ============================================================================
// nn_param_loader
// ----------------------------------------------------------------------------
// Upstream configuration stage for the 4-layer MNIST classifier core.
//
// Takes a packetised word stream (valid/ready) made of
//     header  : [15:14] kind (01 weight, 10 bias), [13:8] layer, [7:0] neuron
//     length  : payload word count N
//     payload : N weight words, or exactly one bias word
// and turns it into the weightValid/biasValid strobes and target-address
// registers that Layer_1..Layer_4 consume. Malformed packets raise a
// one-cycle load_err. Every fully delivered packet raises a one-cycle
// load_done and increments a saturating load_count.
//
// Ports
//   clk               in   rising-edge clock
//   reset_n           in   asynchronous active-low reset
//   s_data            in   stream word
//   s_valid           in   s_data valid
//   s_ready           out  loader can accept a word (low in reset and abort)
//   abort             in   synchronous packet abort, back to header state
//   weightValid       out  one-cycle strobe qualifying weightValue
//   weightValue       out  weight word
//   biasValid         out  one-cycle strobe qualifying biasValue
//   biasValue         out  bias word
//   config_layer_num  out  target layer from the last good header
//   config_neuron_num out  target neuron from the last good header
//   load_done         out  one-cycle pulse, packet fully delivered
//   load_err          out  one-cycle pulse, packet rejected or aborted
//   load_count        out  completed packets, saturates at 16'hFFFF
// ============================================================================
module nn_param_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_LAYERS = 4,
    parameter int MAX_WORDS  = 784
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  abort,
    output logic                  weightValid,
    output logic [DATA_WIDTH-1:0] weightValue,
    output logic                  biasValid,
    output logic [DATA_WIDTH-1:0] biasValue,
    output logic [15:0]           config_layer_num,
    output logic [15:0]           config_neuron_num,
    output logic                  load_done,
    output logic                  load_err,
    output logic [15:0]           load_count
);

    // Remaining-word counter only ever holds a legal length (<= MAX_WORDS).
    localparam int CNT_W = $clog2(MAX_WORDS + 1);

    localparam logic [DATA_WIDTH-1:0] MAX_LEN   = DATA_WIDTH'(MAX_WORDS);
    localparam logic [DATA_WIDTH-1:0] ONE_WORD  = DATA_WIDTH'(1);
    localparam logic [5:0]            MAX_LAYER = 6'(NUM_LAYERS);

    localparam logic [1:0] KIND_WEIGHT = 2'b01;
    localparam logic [1:0] KIND_BIAS   = 2'b10;

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_LEN  = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    state_t           state;
    logic             is_bias;      // kind latched from the current good header
    logic [CNT_W-1:0] remaining;    // payload words still expected
    logic             ready_q;      // low only while (and right after) reset

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    // NOTE: s_ready is combinational on abort so an aborting cycle never
    // consumes the word on the bus; everything else about it is registered.
    assign s_ready = ready_q && !abort;

    logic accept;
    assign accept = s_valid && s_ready;

    // ------------------------------------------------------------------------
    // Header / length decode (pure combinational, used only on accept)
    // ------------------------------------------------------------------------
    logic [1:0] hdr_kind;
    logic [5:0] hdr_layer;
    logic [7:0] hdr_neuron;
    logic       hdr_good;
    logic       len_good;

    always_comb begin
        hdr_kind   = s_data[15:14];
        hdr_layer  = s_data[13:8];
        hdr_neuron = s_data[7:0];

        hdr_good = ((hdr_kind == KIND_WEIGHT) || (hdr_kind == KIND_BIAS)) &&
                   (hdr_layer != 6'd0) && (hdr_layer <= MAX_LAYER);

        // A bias packet carries exactly one word; a weight packet carries up
        // to one full Layer_1 fan-in.
        if (is_bias) begin
            len_good = (s_data == ONE_WORD);
        end else begin
            len_good = (s_data != '0) && (s_data <= MAX_LEN);
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------------
    // NOTE: every state and output register here uses non-blocking
    // assignments so all of them update from the same pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= ST_HDR;
            is_bias           <= 1'b0;
            remaining         <= '0;
            ready_q           <= 1'b0;
            weightValid       <= 1'b0;
            weightValue       <= '0;
            biasValid         <= 1'b0;
            biasValue         <= '0;
            config_layer_num  <= '0;
            config_neuron_num <= '0;
            load_done         <= 1'b0;
            load_err          <= 1'b0;
            load_count        <= '0;
        end else begin
            // Pulses default low; the value registers simply hold.
            ready_q     <= 1'b1;
            weightValid <= 1'b0;
            biasValid   <= 1'b0;
            load_done   <= 1'b0;
            load_err    <= 1'b0;

            if (abort) begin
                // Abort beats any transfer. A packet already past its header
                // is reported as rejected; a bare header state is not.
                if (state != ST_HDR) begin
                    load_err <= 1'b1;
                end
                state     <= ST_HDR;
                remaining <= '0;
            end else if (accept) begin
                case (state)
                    ST_HDR: begin
                        if (hdr_good) begin
                            is_bias           <= (hdr_kind == KIND_BIAS);
                            config_layer_num  <= {10'd0, hdr_layer};
                            config_neuron_num <= {8'd0, hdr_neuron};
                            state             <= ST_LEN;
                        end else begin
                            // Rejected header leaves the target untouched.
                            load_err <= 1'b1;
                        end
                    end

                    ST_LEN: begin
                        if (len_good) begin
                            remaining <= s_data[CNT_W-1:0];
                            state     <= ST_LOAD;
                        end else begin
                            load_err <= 1'b1;
                            state    <= ST_HDR;
                        end
                    end

                    ST_LOAD: begin
                        if (is_bias) begin
                            biasValid <= 1'b1;
                            biasValue <= s_data;
                        end else begin
                            weightValid <= 1'b1;
                            weightValue <= s_data;
                        end
                        remaining <= remaining - CNT_W'(1);

                        // Last word: done pulse lines up with its strobe.
                        if (remaining == CNT_W'(1)) begin
                            load_done <= 1'b1;
                            state     <= ST_HDR;
                            if (load_count != 16'hFFFF) begin
                                load_count <= load_count + 16'd1;
                            end
                        end
                    end

                    default: begin
                        state <= ST_HDR;
                    end
                endcase
            end
        end
    end

endmodule
